stack_sequencer: RTL and testbench

- Multi-cycle controller directly upstream of memory_datapath.
- Owns the stack pointer and sequences push, pop, call-save (push RA) and frame-adjust operations.
- Drives memory_datapath's MemWrite, MemSrc, MemDst and sp_in, and captures its mem_out for pops.
- The main control FSM issues one operation with a start pulse and waits for done.

---
 rtl/stack_sequencer_pkg.sv | 50 +++++
 rtl/stack_sequencer_bounds_check.sv | 25 ++
 rtl/stack_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer: state, op and memory-port codes.
// The op, MemSrc and MemDst codes match the ones used by control and memory_datapath.
package stack_sequencer_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WRITE   = 2'b01,
        ST_READ    = 2'b10,
        ST_CAPTURE = 2'b11
    } state_t;

    // Operation encodings on the op input
    localparam logic [2:0] OP_PUSH_MARY    = 3'b000;
    localparam logic [2:0] OP_PUSH_SHELLEY = 3'b001;
    localparam logic [2:0] OP_PUSH_RA      = 3'b010;
    localparam logic [2:0] OP_POP          = 3'b011;
    localparam logic [2:0] OP_ADJUST       = 3'b100;

    // MemDst address-select codes: 000 = pc, 100 = sp+2
    localparam logic [2:0] MEM_DST_PC  = 3'b000;
    localparam logic [2:0] MEM_DST_SP2 = 3'b100;

    // MemSrc write-data select codes
    localparam logic [1:0] MEM_SRC_MARY    = 2'b00;
    localparam logic [1:0] MEM_SRC_SHELLEY = 2'b01;
    localparam logic [1:0] MEM_SRC_RA      = 2'b10;

    // Default stack bounds
    localparam logic [15:0] DEF_STACK_TOP   = 16'h7FFE;
    localparam logic [15:0] DEF_STACK_LIMIT = 16'h7000;

    // SP deltas for the fixed-size operations
    localparam logic [15:0] DELTA_PUSH = 16'hFFFE;
    localparam logic [15:0] DELTA_POP  = 16'h0002;
    localparam logic [15:0] DELTA_NONE = 16'h0000;

    // Maps a push op onto the write-data source it stores
    function automatic logic [1:0] op_to_src(input logic [2:0] op_code);
        logic [1:0] src;
        case (op_code)
            OP_PUSH_MARY:    src = MEM_SRC_MARY;
            OP_PUSH_SHELLEY: src = MEM_SRC_SHELLEY;
            OP_PUSH_RA:      src = MEM_SRC_RA;
            default:         src = MEM_SRC_MARY;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/stack_sequencer_bounds_check.sv
// Combinational SP bounds check: adds a signed delta to SP without 16-bit wrap
// and flags results below the limit (overflow) or above the top (underflow).
module stack_sequencer_bounds_check
    import stack_sequencer_pkg::*;
(
    input  logic [15:0] sp,
    input  logic [15:0] delta,
    input  logic [15:0] limit,
    input  logic [15:0] top,
    output logic [15:0] new_sp,
    output logic        ovf,
    output logic        unf
);

    logic signed [16:0] sum_s;

    // Widen to 17-bit signed so a large negative delta cannot wrap past zero
    always_comb begin
        sum_s  = $signed({1'b0, sp}) + $signed({delta[15], delta});
        new_sp = sum_s[15:0];
        ovf    = (sum_s < $signed({1'b0, limit}));
        unf    = (sum_s > $signed({1'b0, top}));
    end

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns SP and sequences push, pop, call-save and frame-adjust
// operations on the memory_datapath port. One op per start pulse, ends with done.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [15:0] STACK_TOP    = DEF_STACK_TOP,
    parameter logic [15:0] STACK_LIMIT  = DEF_STACK_LIMIT,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] adj_imm,
    input  logic [15:0] mem_out,
    output logic [15:0] sp_out,
    output logic        MemWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic        mem_busy,
    output logic        busy,
    output logic        done,
    output logic [15:0] pop_data,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic        err_illegal
);

    // READ lasts READ_LATENCY cycles; the counter is loaded with one less
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] sp_r;
    logic [15:0] pop_data_r;
    logic [1:0]  mem_src_r;
    logic [1:0]  lat_cnt_r;
    logic        done_r;
    logic        err_ovf_r;
    logic        err_unf_r;
    logic        err_ill_r;

    logic [15:0] delta_s;
    logic [15:0] chk_sp_s;
    logic        chk_ovf_s;
    logic        chk_unf_s;

    logic        mem_write_s;
    logic [1:0]  mem_src_s;
    logic [2:0]  mem_dst_s;
    logic        mem_busy_s;
    logic        busy_s;

    // Select the SP delta implied by the op presented in IDLE
    always_comb begin
        delta_s = DELTA_NONE;
        case (op)
            OP_PUSH_MARY,
            OP_PUSH_SHELLEY,
            OP_PUSH_RA: delta_s = DELTA_PUSH;
            OP_POP:     delta_s = DELTA_POP;
            OP_ADJUST:  delta_s = adj_imm & 16'hFFFE;
            default:    delta_s = DELTA_NONE;
        endcase
    end

    stack_sequencer_bounds_check u_bounds (
        .sp     (sp_r),
        .delta  (delta_s),
        .limit  (STACK_LIMIT),
        .top    (STACK_TOP),
        .new_sp (chk_sp_s),
        .ovf    (chk_ovf_s),
        .unf    (chk_unf_s)
    );

    // State register; reset abandons any in-flight op immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: only pushes and pops that pass the bounds check leave IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_PUSH_MARY,
                        OP_PUSH_SHELLEY,
                        OP_PUSH_RA: state_nxt_s = chk_ovf_s ? ST_IDLE : ST_WRITE;
                        OP_POP:     state_nxt_s = chk_unf_s ? ST_IDLE : ST_READ;
                        default:    state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
            ST_READ: begin
                if (lat_cnt_r == 2'd0) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory-port outputs decoded from state so reset drops them at once
    always_comb begin
        mem_write_s = 1'b0;
        mem_src_s   = MEM_SRC_MARY;
        mem_dst_s   = MEM_DST_PC;
        mem_busy_s  = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_WRITE: begin
                mem_write_s = 1'b1;
                mem_src_s   = mem_src_r;
                mem_dst_s   = MEM_DST_SP2;
                mem_busy_s  = 1'b1;
                busy_s      = 1'b1;
            end
            ST_READ,
            ST_CAPTURE: begin
                mem_dst_s  = MEM_DST_SP2;
                mem_busy_s = 1'b1;
                busy_s     = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // SP, pop data, latched source, latency counter and completion/error pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_r       <= STACK_TOP;
            pop_data_r <= 16'h0000;
            mem_src_r  <= MEM_SRC_MARY;
            lat_cnt_r  <= 2'd0;
            done_r     <= 1'b0;
            err_ovf_r  <= 1'b0;
            err_unf_r  <= 1'b0;
            err_ill_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
            err_ill_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_PUSH_MARY,
                            OP_PUSH_SHELLEY,
                            OP_PUSH_RA: begin
                                if (chk_ovf_s) begin
                                    done_r    <= 1'b1;
                                    err_ovf_r <= 1'b1;
                                end else begin
                                    sp_r      <= chk_sp_s;
                                    mem_src_r <= op_to_src(op);
                                end
                            end
                            OP_POP: begin
                                if (chk_unf_s) begin
                                    done_r    <= 1'b1;
                                    err_unf_r <= 1'b1;
                                end else begin
                                    lat_cnt_r <= LAT_LOAD;
                                end
                            end
                            OP_ADJUST: begin
                                done_r <= 1'b1;
                                if (chk_ovf_s) begin
                                    err_ovf_r <= 1'b1;
                                end else if (chk_unf_s) begin
                                    err_unf_r <= 1'b1;
                                end else begin
                                    sp_r <= chk_sp_s;
                                end
                            end
                            default: begin
                                done_r    <= 1'b1;
                                err_ill_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    done_r <= 1'b1;
                end
                ST_READ: begin
                    if (lat_cnt_r != 2'd0) begin
                        lat_cnt_r <= lat_cnt_r - 2'd1;
                    end else begin
                        lat_cnt_r <= 2'd0;
                    end
                end
                ST_CAPTURE: begin
                    pop_data_r <= mem_out;
                    sp_r       <= sp_r + DELTA_POP;
                    done_r     <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign sp_out        = sp_r;
    assign pop_data      = pop_data_r;
    assign MemWrite      = mem_write_s;
    assign MemSrc        = mem_src_s;
    assign MemDst        = mem_dst_s;
    assign mem_busy      = mem_busy_s;
    assign busy          = busy_s;
    assign done          = done_r;
    assign err_overflow  = err_ovf_r;
    assign err_underflow = err_unf_r;
    assign err_illegal   = err_ill_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small word memory standing in for
// memory_datapath (address sp+2 when MemDst=100, one-cycle registered read).
module tb_stack_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] adj_imm;
    logic [15:0] mem_out;
    logic [15:0] sp_out;
    logic        MemWrite;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst;
    logic        mem_busy;
    logic        busy;
    logic        done;
    logic [15:0] pop_data;
    logic        err_overflow;
    logic        err_underflow;
    logic        err_illegal;

    logic [15:0] mary;
    logic [15:0] shelley;
    logic [15:0] ra;
    logic [15:0] mem [0:65535];
    logic [15:0] addr_s;
    logic [15:0] wdata_s;

    int checks;
    int errors;

    stack_sequencer #(
        .STACK_TOP    (16'h7FFE),
        .STACK_LIMIT  (16'h7000),
        .READ_LATENCY (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .op            (op),
        .adj_imm       (adj_imm),
        .mem_out       (mem_out),
        .sp_out        (sp_out),
        .MemWrite      (MemWrite),
        .MemSrc        (MemSrc),
        .MemDst        (MemDst),
        .mem_busy      (mem_busy),
        .busy          (busy),
        .done          (done),
        .pop_data      (pop_data),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_illegal   (err_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: address and write-data muxes of memory_datapath
    always_comb begin
        addr_s  = (MemDst == 3'b100) ? (sp_out + 16'd2) : 16'h0000;
        wdata_s = (MemSrc == 2'b01) ? shelley : ((MemSrc == 2'b10) ? ra : mary);
    end

    // Synchronous write and one-cycle registered read
    always @(posedge clock) begin
        if (MemWrite) mem[addr_s] <= wdata_s;
        mem_out <= mem[addr_s];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an op for exactly one sampling edge; returns in the cycle after it
    task automatic issue(input logic [2:0] o, input logic [15:0] imm);
        op      = o;
        adj_imm = imm;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        checks++; if (sp_out !== 16'h7FFE) begin errors++; $display("FAIL rst_sp: got %h exp %h", sp_out, 16'h7FFE); end
        checks++; if (pop_data !== 16'h0000) begin errors++; $display("FAIL rst_pop_data: got %h exp %h", pop_data, 16'h0000); end
        checks++; if ({MemWrite, MemDst, MemSrc, mem_busy, busy} !== 8'h00) begin errors++; $display("FAIL rst_port: got %b exp %b", {MemWrite, MemDst, MemSrc, mem_busy, busy}, 8'h00); end
        checks++; if ({done, err_overflow, err_underflow, err_illegal} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b exp %b", {done, err_overflow, err_underflow, err_illegal}, 4'b0000); end
        @(negedge clock) reset_n = 1'b1;
        step();
        checks++; if ({busy, sp_out} !== {1'b0, 16'h7FFE}) begin errors++; $display("FAIL rst_release: got %h exp %h", {busy, sp_out}, {1'b0, 16'h7FFE}); end
    endtask

    task automatic test_push_mary();
        mary = 16'hBEEF;
        issue(3'b000, 16'h0000);
        checks++; if ({MemWrite, MemDst, MemSrc} !== 6'b1_100_00) begin errors++; $display("FAIL push_write_port: got %b exp %b", {MemWrite, MemDst, MemSrc}, 6'b1_100_00); end
        checks++; if (sp_out !== 16'h7FFC) begin errors++; $display("FAIL push_sp: got %h exp %h", sp_out, 16'h7FFC); end
        checks++; if ({mem_busy, busy, done} !== 3'b110) begin errors++; $display("FAIL push_busy_k1: got %b exp %b", {mem_busy, busy, done}, 3'b110); end
        step();
        checks++; if ({done, err_overflow, MemWrite, busy} !== 4'b1000) begin errors++; $display("FAIL push_done_k2: got %b exp %b", {done, err_overflow, MemWrite, busy}, 4'b1000); end
        checks++; if (mem[16'h7FFE] !== 16'hBEEF) begin errors++; $display("FAIL push_mem: got %h exp %h", mem[16'h7FFE], 16'hBEEF); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL push_done_width: got %b exp %b", done, 1'b0); end
    endtask

    task automatic test_push_pop_ra();
        ra = 16'h0042;
        issue(3'b010, 16'h0000);
        checks++; if ({MemSrc, sp_out} !== {2'b10, 16'h7FFA}) begin errors++; $display("FAIL ra_write: got %h exp %h", {MemSrc, sp_out}, {2'b10, 16'h7FFA}); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ra_done: got %b exp %b", done, 1'b1); end
        step();
        issue(3'b011, 16'h0000);
        checks++; if ({MemDst, MemWrite, mem_busy, busy, done} !== 7'b100_0_1_1_0) begin errors++; $display("FAIL pop_read: got %b exp %b", {MemDst, MemWrite, mem_busy, busy, done}, 7'b100_0_1_1_0); end
        step();
        checks++; if ({MemDst, done, sp_out} !== {3'b100, 1'b0, 16'h7FFA}) begin errors++; $display("FAIL pop_capture: got %h exp %h", {MemDst, done, sp_out}, {3'b100, 1'b0, 16'h7FFA}); end
        step();
        checks++; if ({done, err_overflow, err_underflow, err_illegal} !== 4'b1000) begin errors++; $display("FAIL pop_done_k3: got %b exp %b", {done, err_overflow, err_underflow, err_illegal}, 4'b1000); end
        checks++; if ({pop_data, sp_out} !== {16'h0042, 16'h7FFC}) begin errors++; $display("FAIL pop_ra_data: got %h exp %h", {pop_data, sp_out}, {16'h0042, 16'h7FFC}); end
        step();
        issue(3'b011, 16'h0000);
        repeat (2) step();
        checks++; if ({done, pop_data, sp_out} !== {1'b1, 16'hBEEF, 16'h7FFE}) begin errors++; $display("FAIL pop_mary_data: got %h exp %h", {done, pop_data, sp_out}, {1'b1, 16'hBEEF, 16'h7FFE}); end
        step();
    endtask

    task automatic test_pop_empty();
        issue(3'b011, 16'h0000);
        checks++; if ({done, err_underflow, err_overflow, err_illegal} !== 4'b1100) begin errors++; $display("FAIL unf_flags: got %b exp %b", {done, err_underflow, err_overflow, err_illegal}, 4'b1100); end
        checks++; if ({MemWrite, MemDst, busy} !== 5'b0_000_0) begin errors++; $display("FAIL unf_port: got %b exp %b", {MemWrite, MemDst, busy}, 5'b0_000_0); end
        checks++; if ({sp_out, pop_data} !== {16'h7FFE, 16'hBEEF}) begin errors++; $display("FAIL unf_regs: got %h exp %h", {sp_out, pop_data}, {16'h7FFE, 16'hBEEF}); end
        step();
        checks++; if ({done, err_underflow} !== 2'b00) begin errors++; $display("FAIL unf_pulse: got %b exp %b", {done, err_underflow}, 2'b00); end
    endtask

    task automatic test_adjust_bounds();
        logic [15:0] exp_sp;
        issue(3'b100, 16'hF00A);
        checks++; if ({done, err_overflow, err_underflow, sp_out} !== {3'b100, 16'h7008}) begin errors++; $display("FAIL adj_down: got %h exp %h", {done, err_overflow, err_underflow, sp_out}, {3'b100, 16'h7008}); end
        step();
        for (int i = 1; i <= 4; i++) begin
            shelley = 16'hA000 + 16'(i);
            exp_sp  = 16'h7008 - 16'(2 * i);
            issue(3'b001, 16'h0000);
            checks++; if ({MemWrite, MemSrc, sp_out} !== {1'b1, 2'b01, exp_sp}) begin errors++; $display("FAIL fill_push%0d: got %h exp %h", i, {MemWrite, MemSrc, sp_out}, {1'b1, 2'b01, exp_sp}); end
            step();
            checks++; if ({done, err_overflow} !== 2'b10) begin errors++; $display("FAIL fill_done%0d: got %b exp %b", i, {done, err_overflow}, 2'b10); end
            step();
        end
        issue(3'b001, 16'h0000);
        checks++; if ({done, err_overflow, MemWrite, busy, sp_out} !== {4'b1100, 16'h7000}) begin errors++; $display("FAIL ovf_push: got %h exp %h", {done, err_overflow, MemWrite, busy, sp_out}, {4'b1100, 16'h7000}); end
        step();
        issue(3'b011, 16'h0000);
        repeat (2) step();
        checks++; if ({pop_data, sp_out} !== {16'hA004, 16'h7002}) begin errors++; $display("FAIL pop_limit: got %h exp %h", {pop_data, sp_out}, {16'hA004, 16'h7002}); end
        step();
        issue(3'b100, 16'h0FFD);
        checks++; if ({done, err_overflow, err_underflow, sp_out} !== {3'b100, 16'h7FFE}) begin errors++; $display("FAIL adj_odd_up: got %h exp %h", {done, err_overflow, err_underflow, sp_out}, {3'b100, 16'h7FFE}); end
        step();
        issue(3'b100, 16'h0100);
        checks++; if ({done, err_overflow, err_underflow, sp_out} !== {3'b101, 16'h7FFE}) begin errors++; $display("FAIL adj_unf: got %h exp %h", {done, err_overflow, err_underflow, sp_out}, {3'b101, 16'h7FFE}); end
        step();
        issue(3'b100, 16'hF000);
        checks++; if ({done, err_overflow, err_underflow, sp_out} !== {3'b110, 16'h7FFE}) begin errors++; $display("FAIL adj_ovf: got %h exp %h", {done, err_overflow, err_underflow, sp_out}, {3'b110, 16'h7FFE}); end
        step();
    endtask

    task automatic test_busy_and_illegal();
        mary = 16'h1234;
        issue(3'b000, 16'h0000);
        op    = 3'b011;
        start = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_write: got %b exp %b", busy, 1'b1); end
        step();
        start = 1'b0;
        checks++; if ({done, sp_out} !== {1'b1, 16'h7FFC}) begin errors++; $display("FAIL busy_done: got %h exp %h", {done, sp_out}, {1'b1, 16'h7FFC}); end
        step();
        checks++; if ({busy, MemDst, done, sp_out} !== {5'b0_000_0, 16'h7FFC}) begin errors++; $display("FAIL busy_ignored: got %h exp %h", {busy, MemDst, done, sp_out}, {5'b0_000_0, 16'h7FFC}); end
        issue(3'b111, 16'h0000);
        checks++; if ({done, err_illegal, err_overflow, err_underflow, busy, sp_out} !== {5'b11000, 16'h7FFC}) begin errors++; $display("FAIL illegal: got %h exp %h", {done, err_illegal, err_overflow, err_underflow, busy, sp_out}, {5'b11000, 16'h7FFC}); end
        step();
        checks++; if ({done, err_illegal} !== 2'b00) begin errors++; $display("FAIL illegal_pulse: got %b exp %b", {done, err_illegal}, 2'b00); end
        issue(3'b011, 16'h0000);
        repeat (2) step();
        checks++; if ({pop_data, sp_out} !== {16'h1234, 16'h7FFE}) begin errors++; $display("FAIL busy_restore: got %h exp %h", {pop_data, sp_out}, {16'h1234, 16'h7FFE}); end
        step();
    endtask

    task automatic test_reset_mid_op();
        mary = 16'h5555;
        issue(3'b000, 16'h0000);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({MemWrite, MemDst, busy, sp_out} !== {5'b0_000_0, 16'h7FFE}) begin errors++; $display("FAIL rst_write: got %h exp %h", {MemWrite, MemDst, busy, sp_out}, {5'b0_000_0, 16'h7FFE}); end
        @(negedge clock) reset_n = 1'b1;
        step();
        checks++; if (mem[16'h7FFE] !== 16'h1234) begin errors++; $display("FAIL rst_write_mem: got %h exp %h", mem[16'h7FFE], 16'h1234); end
        ra = 16'h0042;
        issue(3'b010, 16'h0000);
        repeat (2) step();
        issue(3'b011, 16'h0000);
        checks++; if (MemDst !== 3'b100) begin errors++; $display("FAIL rst_read_pre: got %b exp %b", MemDst, 3'b100); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({MemDst, MemWrite, mem_busy, busy} !== 6'b000_000) begin errors++; $display("FAIL rst_read_port: got %b exp %b", {MemDst, MemWrite, mem_busy, busy}, 6'b000_000); end
        checks++; if ({sp_out, pop_data} !== {16'h7FFE, 16'h0000}) begin errors++; $display("FAIL rst_read_regs: got %h exp %h", {sp_out, pop_data}, {16'h7FFE, 16'h0000}); end
        @(negedge clock) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rst_no_done%0d: got %b exp %b", i, {done, busy}, 2'b00); end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        adj_imm = 16'h0000;
        mary    = 16'h0000;
        shelley = 16'h0000;
        ra      = 16'h0000;
        test_reset();
        test_push_mary();
        test_push_pop_ra();
        test_pop_empty();
        test_adjust_bounds();
        test_busy_and_illegal();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
